// File: rtl/clk_div_monitor.sv
// clk_div_monitor
// Samples a divided clock in the fast clk domain and turns its edges into
// single-cycle enable strobes. It measures each div_clk period in clk cycles,
// reports lock once enough consecutive periods match the expected ratio, and
// raises sticky flags for out-of-tolerance periods and for stalls.
module clk_div_monitor #(
   parameter int EXP_RATIO  = 4,
   parameter int TOL        = 0,
   parameter int LOCK_COUNT = 4,
   parameter int CNT_W      = 8,
   parameter int TIMEOUT    = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_clk,
   input  logic             err_clr,
   output logic             rise_stb,
   output logic             fall_stb,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             locked,
   output logic             err_sticky,
   output logic             stall_sticky
);

   typedef enum logic [1:0] {IDLE, MEASURE, CHECK, LOCKED} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [3:0]       LOCK_C    = 4'(LOCK_COUNT);

   // Saturating increment so a stopped div_clk cannot wrap the counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
   endfunction

   // Absolute deviation of a measured period from the expected ratio.
   function automatic logic in_tol(input logic [CNT_W-1:0] p);
      int dev;
      dev = 32'(p);
      dev = dev - EXP_RATIO;
      if (dev < 0) dev = -dev;
      return (dev <= TOL);
   endfunction

   logic             sync0_q, sync1_q, prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q;
   logic             period_vld_q;
   logic [3:0]       good_q;
   state_t           state_q;
   logic             locked_q;
   logic             err_q;
   logic             stall_q;

   logic [CNT_W-1:0] period_new;
   logic             new_in_tol;
   logic             timeout_hit;

   // Edge strobes come straight from the synchroniser registers.
   assign rise_stb = sync1_q & ~prev_q;
   assign fall_stb = ~sync1_q & prev_q;

   // Value that a rise in this cycle would record, and whether it is acceptable.
   assign period_new  = sat_inc(cnt_q);
   assign new_in_tol  = in_tol(period_new);
   // A rise in the timeout cycle is a normal period, so it takes precedence.
   assign timeout_hit = (state_q != IDLE) && (cnt_q == TIMEOUT_C) && !rise_stb;

   // Counter restarts on each rise and otherwise counts up, saturating.
   always_comb begin
      cnt_d = rise_stb ? '0 : sat_inc(cnt_q);
   end

   // Two-flop synchroniser plus a history flop for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync0_q <= 1'b0;
         sync1_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync0_q <= div_clk;
         sync1_q <= sync0_q;
         prev_q  <= sync1_q;
      end
   end

   // Period counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Lock FSM with registered period, lock and sticky flag outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         good_q       <= 4'd0;
         locked_q     <= 1'b0;
         period_q     <= '0;
         period_vld_q <= 1'b0;
         err_q        <= 1'b0;
         stall_q      <= 1'b0;
      end else begin
         period_vld_q <= 1'b0;
         // Clears come first so a same-cycle set event below overrides them.
         if (err_clr) begin
            err_q   <= 1'b0;
            stall_q <= 1'b0;
         end
         if (rise_stb) begin
            // The first rise after IDLE has no preceding edge to measure from.
            if (state_q != IDLE) begin
               period_q     <= period_new;
               period_vld_q <= 1'b1;
            end
            case (state_q)
               IDLE: begin
                  state_q <= MEASURE;
               end
               MEASURE: begin
                  state_q <= CHECK;
                  good_q  <= new_in_tol ? 4'd1 : 4'd0;
               end
               CHECK: begin
                  if (new_in_tol) begin
                     good_q <= good_q + 4'd1;
                     if ((good_q + 4'd1) >= LOCK_C) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                     end
                  end else begin
                     good_q <= 4'd0;
                     err_q  <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (!new_in_tol) begin
                     state_q  <= CHECK;
                     locked_q <= 1'b0;
                     good_q   <= 4'd0;
                     err_q    <= 1'b1;
                  end
               end
               default: begin
                  state_q  <= IDLE;
                  locked_q <= 1'b0;
                  good_q   <= 4'd0;
               end
            endcase
         end else if (timeout_hit) begin
            state_q  <= IDLE;
            good_q   <= 4'd0;
            locked_q <= 1'b0;
            stall_q  <= 1'b1;
         end
      end
   end

   assign period       = period_q;
   assign period_vld   = period_vld_q;
   assign locked       = locked_q;
   assign err_sticky   = err_q;
   assign stall_sticky = stall_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Testbench for clk_div_monitor: two instances (TOL=0 and TOL=1) share one
// div_clk stimulus and are compared every cycle against a timestamp-based
// reference model, with directed checks at the scenario milestones.
module tb_clk_div_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, div_clk, err_clr;

   logic       rise0, fall0, vld0, lock0, err0, stall0;
   logic [7:0] per0;
   logic       rise1, fall1, vld1, lock1, err1, stall1;
   logic [7:0] per1;

   clk_div_monitor #(.EXP_RATIO(4), .TOL(0), .LOCK_COUNT(4), .CNT_W(8), .TIMEOUT(64)) u0 (
      .clk(clk), .reset(reset), .div_clk(div_clk), .err_clr(err_clr),
      .rise_stb(rise0), .fall_stb(fall0), .period(per0), .period_vld(vld0),
      .locked(lock0), .err_sticky(err0), .stall_sticky(stall0));

   clk_div_monitor #(.EXP_RATIO(4), .TOL(1), .LOCK_COUNT(4), .CNT_W(8), .TIMEOUT(64)) u1 (
      .clk(clk), .reset(reset), .div_clk(div_clk), .err_clr(err_clr),
      .rise_stb(rise1), .fall_stb(fall1), .period(per1), .period_vld(vld1),
      .locked(lock1), .err_sticky(err1), .stall_sticky(stall1));

   int errors = 0;
   int checks = 0;

   // Reference model. h[0..2] = div_clk sampled 1, 2, 3 edges ago.
   // Per instance m (tolerance m): phase 0 idle, 1 first rise seen,
   // 2 counting good periods, 3 locked; periods come from rise timestamps.
   bit h[3];
   int cyc = 0;
   int phase[2], good[2], last_rise[2], m_per[2];
   bit m_vld[2], m_lock[2], m_err[2], m_stall[2];
   bit clr_on_rise = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit d, input bit clr, input bit rst);
      bit rise;
      rise = h[1] & !h[2];
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            phase[m] = 0; good[m] = 0; m_per[m] = 0; m_vld[m] = 0;
            m_lock[m] = 0; m_err[m] = 0; m_stall[m] = 0;
         end else begin
            int p, dv;
            bit ok, se, ss;
            p = cyc - last_rise[m];
            if (p > 255) p = 255;
            dv = p - 4;
            if (dv < 0) dv = -dv;
            ok = (dv <= m);
            se = 0; ss = 0;
            m_vld[m] = 0;
            if (rise) begin
               if (phase[m] != 0) begin
                  m_per[m] = p;
                  m_vld[m] = 1;
               end
               if (phase[m] == 0) phase[m] = 1;
               else if (phase[m] == 1) begin
                  phase[m] = 2;
                  good[m] = ok ? 1 : 0;
               end else if (phase[m] == 2) begin
                  if (ok) begin
                     good[m]++;
                     if (good[m] >= 4) phase[m] = 3;
                  end else begin
                     good[m] = 0; se = 1;
                  end
               end else if (!ok) begin
                  phase[m] = 2; good[m] = 0; se = 1;
               end
               last_rise[m] = cyc;
            end else if (phase[m] != 0 && (cyc - last_rise[m]) == 65) begin
               phase[m] = 0; good[m] = 0; ss = 1;
            end
            m_lock[m]  = (phase[m] == 3);
            m_err[m]   = se | (m_err[m] & !clr);
            m_stall[m] = ss | (m_stall[m] & !clr);
         end
      end
      if (rst) begin
         h[0] = 0; h[1] = 0; h[2] = 0;
      end else begin
         h[2] = h[1]; h[1] = h[0]; h[0] = d;
      end
      cyc++;
   endtask

   task automatic compare_all();
      bit er, ef;
      er = h[1] & !h[2];
      ef = !h[1] & h[2];
      chk("u0.rise_stb", 32'(rise0), 32'(er));
      chk("u0.fall_stb", 32'(fall0), 32'(ef));
      chk("u0.period", 32'(per0), m_per[0]);
      chk("u0.period_vld", 32'(vld0), 32'(m_vld[0]));
      chk("u0.locked", 32'(lock0), 32'(m_lock[0]));
      chk("u0.err_sticky", 32'(err0), 32'(m_err[0]));
      chk("u0.stall_sticky", 32'(stall0), 32'(m_stall[0]));
      chk("u1.rise_stb", 32'(rise1), 32'(er));
      chk("u1.fall_stb", 32'(fall1), 32'(ef));
      chk("u1.period", 32'(per1), m_per[1]);
      chk("u1.period_vld", 32'(vld1), 32'(m_vld[1]));
      chk("u1.locked", 32'(lock1), 32'(m_lock[1]));
      chk("u1.err_sticky", 32'(err1), 32'(m_err[1]));
      chk("u1.stall_sticky", 32'(stall1), 32'(m_stall[1]));
   endtask

   // One clk cycle: drive inputs, take the edge, update the model, compare.
   task automatic tick(input bit d, input bit clr, input bit rst);
      bit c;
      c = clr | (clr_on_rise & h[1] & !h[2]);
      div_clk = d; err_clr = c; reset = rst;
      @(posedge clk);
      model_edge(d, c, rst);
      #1;
      compare_all();
   endtask

   // One div_clk period: hi cycles high, lo cycles low; optional clear on the first cycle.
   task automatic wave(input int hi, input int lo, input bit clr);
      for (int i = 0; i < hi; i++) tick(1'b1, (i == 0) ? clr : 1'b0, 1'b0);
      for (int i = 0; i < lo; i++) tick(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int rises, lock_rises, first_per, vld_rises, vlds, hi, lo;
      reset = 1'b1; div_clk = 1'b0; err_clr = 1'b0;
      for (int m = 0; m < 2; m++) last_rise[m] = 0;

      // Reset state
      repeat (3) tick(1'b0, 1'b0, 1'b1);
      chk("rst.locked", 32'(lock0), 0);
      chk("rst.period", 32'(per0), 0);
      chk("rst.err", 32'(err0), 0);
      chk("rst.stall", 32'(stall0), 0);
      tick(1'b0, 1'b0, 1'b0);

      // Steady divide-by-4: count rises until the first period_vld and lock
      rises = 0; lock_rises = -1; first_per = -1; vld_rises = -1;
      for (int i = 0; i < 48; i++) begin
         tick((i % 4) < 2, 1'b0, 1'b0);
         if (rise0) rises++;
         if (vld0 && vld_rises < 0) begin vld_rises = rises; first_per = per0; end
         if (lock0 && lock_rises < 0) lock_rises = rises;
      end
      chk("div4.first_vld_rise", vld_rises, 2);
      chk("div4.first_period", first_per, 4);
      chk("div4.lock_rise", lock_rises, 5);
      chk("div4.err", 32'(err0), 0);

      // Single 6-cycle period while locked
      wave(3, 3, 1'b0);
      wave(2, 2, 1'b0);
      chk("bad6.err", 32'(err0), 1);
      chk("bad6.unlocked", 32'(lock0), 0);
      repeat (3) wave(2, 2, 1'b0);
      chk("bad6.relock_early", 32'(lock0), 0);
      wave(2, 2, 1'b0);
      chk("bad6.relock", 32'(lock0), 1);

      // Stall: hold low for 70 cycles
      repeat (70) tick(1'b0, 1'b0, 1'b0);
      chk("stall.sticky", 32'(stall0), 1);
      chk("stall.unlocked", 32'(lock0), 0);
      repeat (4) wave(2, 2, 1'b0);
      chk("stall.relock_4", 32'(lock0), 0);
      wave(2, 2, 1'b0);
      chk("stall.relock_5", 32'(lock0), 1);

      // err_clr coincident with a bad-period rise: set wins
      wave(2, 2, 1'b1);
      chk("clr.err0", 32'(err0), 0);
      chk("clr.stall0", 32'(stall0), 0);
      clr_on_rise = 1'b1;
      wave(3, 3, 1'b0);
      wave(2, 2, 1'b0);
      clr_on_rise = 1'b0;
      chk("clr.coincident", 32'(err0), 1);
      wave(2, 2, 1'b1);
      chk("clr.later", 32'(err0), 0);

      // Alternating 3/5 periods: locks with TOL=1, never with TOL=0
      wave(2, 2, 1'b1);
      repeat (10) begin
         wave(2, 1, 1'b0);
         wave(2, 3, 1'b0);
      end
      chk("alt.tol1_locked", 32'(lock1), 1);
      chk("alt.tol1_err", 32'(err1), 0);
      chk("alt.tol0_locked", 32'(lock0), 0);
      chk("alt.tol0_err", 32'(err0), 1);

      // Randomised periods, clears and occasional stalls
      repeat (40) begin
         hi = $urandom_range(4, 1);
         lo = ($urandom_range(9, 0) == 0) ? $urandom_range(75, 60) : $urandom_range(4, 1);
         wave(hi, lo, $urandom_range(5, 0) == 0);
      end

      // Reset while locked, mid-period
      repeat (7) wave(2, 2, 1'b0);
      chk("rstmid.locked_before", 32'(lock0), 1);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      chk("rstmid.locked", 32'(lock0), 0);
      chk("rstmid.period", 32'(per0), 0);
      chk("rstmid.vld", 32'(vld0), 0);
      chk("rstmid.rise", 32'(rise0), 0);
      vlds = 0;
      tick(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick(i < 2, 1'b0, 1'b0);
         if (vld0) vlds++;
      end
      chk("rstmid.no_first_vld", vlds, 0);
      repeat (2) wave(2, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
